// File: rtl/reg_bank_sequencer_pkg.sv
// Shared definitions for the register-bank sequencer: opcode constants and FSM states.
// Ports: none (package only).
// Imported by the sequencer top with import reg_seq_pkg::*.
package reg_seq_pkg;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EX   = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_e;

endpackage

// File: rtl/reg_bank_sequencer_if.sv
// Bundle of command/response handshake, register_bank and ALU signals of the sequencer.
// Ports: cmd_* / rsp_* requester side, rb_* register_bank side, alu_* external ALU side.
// slave = the sequencer itself; master = the environment (decoder, bank, ALU).
interface reg_bank_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [SEL_W-1:0]  cmd_rx;
  logic [SEL_W-1:0]  cmd_ry;
  logic [DATA_W-1:0] cmd_imm;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rb_read_en;
  logic              rb_write_en;
  logic [SEL_W-1:0]  rb_rx_sel;
  logic [SEL_W-1:0]  rb_ry_sel;
  logic [DATA_W-1:0] rb_wr_data;
  logic [DATA_W-1:0] rb_bus_data;
  logic [DATA_W-1:0] rb_rx_data;
  logic [DATA_W-1:0] rb_ry_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rx, cmd_ry, cmd_imm,
    input  rb_bus_data, rb_rx_data, rb_ry_data, alu_result,
    output cmd_ready, rsp_valid, rsp_data,
    output rb_read_en, rb_write_en, rb_rx_sel, rb_ry_sel, rb_wr_data,
    output alu_a, alu_b
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rx, cmd_ry, cmd_imm,
    output rb_bus_data, rb_rx_data, rb_ry_data, alu_result,
    input  cmd_ready, rsp_valid, rsp_data,
    input  rb_read_en, rb_write_en, rb_rx_sel, rb_ry_sel, rb_wr_data,
    input  alu_a, alu_b
  );

endinterface

// File: rtl/reg_bank_sequencer.sv
// Sequences one register-file command at a time (LDI/MOV/ALU/OUT) onto register_bank.
// Ports: clk, rst_n (sync, active-low), bus = reg_bank_sequencer_if.slave.
// Latency accept->rsp_valid: LDI/OUT 2, MOV/ALU 3; cmd_ready low while busy.
module reg_bank_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_bank_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [SEL_W-1:0]  rx_q, rx_d;
  logic [SEL_W-1:0]  ry_q, ry_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d = bus.cmd_op;
          rx_d = bus.cmd_rx;
          ry_d = bus.cmd_ry;
          case (bus.cmd_op)
            OP_LDI: begin
              data_d  = bus.cmd_imm;
              state_d = S_WR;
            end
            OP_ALU:  state_d = S_EX;
            default: state_d = S_RD;  // MOV and OUT both read Ry first
          endcase
        end
      end
      S_RD: begin
        data_d  = bus.rb_bus_data;
        state_d = (op_q == OP_MOV) ? S_WR : S_RSP;
      end
      S_EX: begin
        data_d  = bus.alu_result;
        state_d = S_WR;
      end
      S_WR:    state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LDI;
      rx_q    <= '0;
      ry_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      data_q  <= data_d;
    end
  end

  // Every output is a register or a pure decode of state_q, so the
  // requester never sees a combinational path from cmd_* to outputs.
  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.rb_read_en  = (state_q == S_RD);
  assign bus.rb_write_en = (state_q == S_WR);
  assign bus.rsp_valid   = (state_q == S_RSP);
  assign bus.rsp_data    = data_q;
  assign bus.rb_wr_data  = data_q;
  assign bus.rb_rx_sel   = rx_q;
  assign bus.rb_ry_sel   = ry_q;
  // Operands are only presented while the ALU result is being captured.
  assign bus.alu_a       = (state_q == S_EX) ? bus.rb_rx_data : '0;
  assign bus.alu_b       = (state_q == S_EX) ? bus.rb_ry_data : '0;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
module tb_reg_bank_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic bank_clr;
  int   n_chk = 0;
  int   n_err = 0;
  int   overlap = 0;

  always #5 clk = ~clk;

  reg_bank_sequencer_if #(.DATA_W(8), .SEL_W(3)) bus ();

  reg_bank_sequencer #(.DATA_W(8), .SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment: a register_bank stand-in and an adder ALU.
  logic [7:0] bank [8];
  assign bus.rb_bus_data = bus.rb_read_en ? bank[bus.rb_ry_sel] : 8'h00;
  assign bus.rb_rx_data  = bank[bus.rb_rx_sel];
  assign bus.rb_ry_data  = bank[bus.rb_ry_sel];
  assign bus.alu_result  = bus.alu_a + bus.alu_b;

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
    end else if (bus.rb_write_en) begin
      bank[bus.rb_rx_sel] <= bus.rb_wr_data;
    end
  end

  always @(negedge clk) begin
    if (bus.rb_read_en && bus.rb_write_en) overlap++;
  end

  // Architectural reference: register contents after each completed command.
  logic [7:0] model_rf [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                        input logic [7:0] imm, input bit junk);
    logic [7:0] exp_val;
    int exp_lat, exp_rd, exp_wr;
    int rd_cnt, wr_cnt, rsp_cnt, rsp_k, ready_hi, w;
    logic [2:0] rd_sel, wr_sel;
    logic [7:0] wr_dat, rsp_dat;
    case (op)
      2'b00:   begin exp_val = imm;                          exp_lat = 2; exp_rd = 0; exp_wr = 1; end
      2'b01:   begin exp_val = model_rf[ry];                 exp_lat = 3; exp_rd = 1; exp_wr = 1; end
      2'b10:   begin exp_val = 8'(model_rf[rx] + model_rf[ry]); exp_lat = 3; exp_rd = 0; exp_wr = 1; end
      default: begin exp_val = model_rf[ry];                 exp_lat = 2; exp_rd = 1; exp_wr = 0; end
    endcase
    rd_cnt = 0; wr_cnt = 0; rsp_cnt = 0; rsp_k = 0; ready_hi = 0;
    rd_sel = '0; wr_sel = '0; wr_dat = '0; rsp_dat = '0;
    @(negedge clk);
    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_before", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_rx    = rx;
    bus.cmd_ry    = ry;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (junk) begin
      // A different command held valid while busy must not be taken.
      bus.cmd_op  = 2'b00;
      bus.cmd_rx  = ~rx;
      bus.cmd_ry  = ~ry;
      bus.cmd_imm = ~imm;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.rb_read_en)  begin rd_cnt++; rd_sel = bus.rb_ry_sel; end
      if (bus.rb_write_en) begin wr_cnt++; wr_sel = bus.rb_rx_sel; wr_dat = bus.rb_wr_data; end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (rsp_k == 0) begin rsp_k = k; rsp_dat = bus.rsp_data; end
      end
      if (k <= exp_lat && bus.cmd_ready) ready_hi++;
      if (k == 1 && op == 2'b10) begin
        chk("alu_a", 32'(bus.alu_a), 32'(model_rf[rx]));
        chk("alu_b", 32'(bus.alu_b), 32'(model_rf[ry]));
      end
      if (junk && k == exp_lat) bus.cmd_valid = 1'b0;
    end
    chk("latency",  32'(rsp_k),   32'(exp_lat));
    chk("rsp_cnt",  32'(rsp_cnt), 32'd1);
    chk("rsp_data", 32'(rsp_dat), 32'(exp_val));
    chk("rd_cnt",   32'(rd_cnt),  32'(exp_rd));
    chk("wr_cnt",   32'(wr_cnt),  32'(exp_wr));
    chk("busy_ready", 32'(ready_hi), 32'd0);
    if (exp_rd == 1) chk("rd_ry_sel", 32'(rd_sel), 32'(ry));
    if (exp_wr == 1) begin
      chk("wr_rx_sel", 32'(wr_sel), 32'(rx));
      chk("wr_data",   32'(wr_dat), 32'(exp_val));
      model_rf[rx] = exp_val;
    end
  endtask

  initial begin
    int rsp_seen, wr_seen;
    logic [1:0] rop;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_rx    = 3'd0;
    bus.cmd_ry    = 3'd0;
    bus.cmd_imm   = 8'h00;
    for (int i = 0; i < 8; i++) model_rf[i] = 8'h00;
    rst_n    = 1'b0;
    bank_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready),   32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid),   32'd0);
    chk("rst_read_en",   32'(bus.rb_read_en),  32'd0);
    chk("rst_write_en",  32'(bus.rb_write_en), 32'd0);
    chk("rst_rx_sel",    32'(bus.rb_rx_sel),   32'd0);
    chk("rst_ry_sel",    32'(bus.rb_ry_sel),   32'd0);
    chk("rst_wr_data",   32'(bus.rb_wr_data),  32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),    32'd0);
    rst_n    = 1'b1;
    bank_clr = 1'b0;

    // Directed scenarios.
    do_cmd(2'b00, 3'd4, 3'd0, 8'hAA, 1'b0);
    chk("bank_r4", 32'(bank[4]), 32'h0AA);
    do_cmd(2'b00, 3'd3, 3'd0, 8'h01, 1'b0);
    do_cmd(2'b01, 3'd0, 3'd3, 8'h00, 1'b0);
    do_cmd(2'b00, 3'd1, 3'd0, 8'hF0, 1'b0);
    do_cmd(2'b00, 3'd2, 3'd0, 8'h20, 1'b0);
    do_cmd(2'b10, 3'd1, 3'd2, 8'h00, 1'b0);
    chk("bank_r1_wrap", 32'(bank[1]), 32'h010);
    do_cmd(2'b00, 3'd3, 3'd0, 8'h5A, 1'b0);
    do_cmd(2'b11, 3'd0, 3'd3, 8'h00, 1'b0);
    do_cmd(2'b01, 3'd5, 3'd4, 8'h00, 1'b1);
    do_cmd(2'b10, 3'd6, 3'd6, 8'h00, 1'b0);

    // Reset while a MOV is in its read cycle aborts it.
    @(negedge clk);
    bus.cmd_op = 2'b01; bus.cmd_rx = 3'd6; bus.cmd_ry = 3'd4; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rd", 32'(bus.rb_read_en), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_cmd_ready", 32'(bus.cmd_ready),   32'd1);
    chk("abort_read_en",   32'(bus.rb_read_en),  32'd0);
    chk("abort_write_en",  32'(bus.rb_write_en), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid),   32'd0);
    rst_n = 1'b1;
    rsp_seen = 0; wr_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
      if (bus.rb_write_en) wr_seen++;
    end
    chk("abort_no_rsp", 32'(rsp_seen), 32'd0);
    chk("abort_no_wr",  32'(wr_seen),  32'd0);

    // Randomized traffic against the architectural model.
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      do_cmd(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             8'($urandom), ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), 32'(bank[i]), 32'(model_rf[i]));
    chk("rd_wr_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_sequencer.md
Name: reg_bank_sequencer

Overview:
Control FSM that sits between the instruction decoder and register_bank and sequences every register-file access. It accepts one register command at a time over a valid/ready handshake and drives the bank's read_en, write_en, rx/ry selectors and in_data. It captures the bank's bus and ALU results, then returns a one-cycle response. The ALU stays external and combinational; this block only presents operands and captures the result.

Parameters:
DATA_W, 8, register and bus data width
SEL_W, 3, register selector width (2**SEL_W registers)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_op  in  2  00 LDI, 01 MOV, 10 ALU, 11 OUT
cmd_rx  in  SEL_W  destination / first-operand register
cmd_ry  in  SEL_W  source / second-operand register
cmd_imm  in  DATA_W  immediate for LDI
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_W  value written (LDI/MOV/ALU) or value read (OUT)
rb_read_en  out  1  to register_bank read_en (Ry onto bus)
rb_write_en  out  1  to register_bank write_en
rb_rx_sel  out  SEL_W  to in_rx_selector
rb_ry_sel  out  SEL_W  to in_ry_selector
rb_wr_data  out  DATA_W  to in_data
rb_bus_data  in  DATA_W  from out_bus_data
rb_rx_data  in  DATA_W  from out_rx_data
rb_ry_data  in  DATA_W  from out_ry_data
alu_a  out  DATA_W  ALU operand A (= rb_rx_data in EX)
alu_b  out  DATA_W  ALU operand B (= rb_ry_data in EX)
alu_result  in  DATA_W  combinational ALU result

Behaviour:
- One clock domain. Reset is synchronous, active-low. While rst_n=0 at an edge: state<=IDLE, and cmd_ready=1, rsp_valid=0, rb_read_en=0, rb_write_en=0, rb_rx_sel=0, rb_ry_sel=0, rb_wr_data=0, rsp_data=0, data_q=0.
- States: IDLE, RD, EX, WR, RSP. All outputs are registered or decoded from state only; none are combinational from cmd_*.
- IDLE: cmd_ready=1. On cmd_valid, latch op/rx/ry/imm and drive rb_rx_sel=cmd_rx, rb_ry_sel=cmd_ry. Next state: LDI->WR with data_q<=cmd_imm; MOV->RD; OUT->RD; ALU->EX. cmd_valid=0 leaves the block in IDLE.
- RD: rb_read_en=1 for exactly one cycle; data_q<=rb_bus_data at the closing edge. Next state: MOV->WR, OUT->RSP.
- EX: alu_a=rb_rx_data, alu_b=rb_ry_data; data_q<=alu_result at the closing edge; next state WR.
- WR: rb_write_en=1 for exactly one cycle, rb_wr_data=data_q, rb_rx_sel=latched rx; next state RSP.
- RSP: rsp_valid=1 for exactly one cycle, rsp_data=data_q; next state IDLE.
- Latency, counting from the accept edge to the rsp_valid cycle: LDI 2, OUT 2, MOV 3, ALU 3. cmd_ready is low from the accept edge until RSP exits, so there is at most one command in flight.
- cmd_valid while cmd_ready=0 is ignored. The requester holds cmd_* stable until accepted; inputs are not sampled outside IDLE.
- Invariant: rb_read_en and rb_write_en are never high in the same cycle.
- Selectors hold their latched values from the accept edge through RSP. In IDLE they keep their last values; they are not cleared.
- MOV with rx==ry and ALU with rx==ry are legal. They read, then write the same register, with no special case.
- Outside WR, rb_wr_data holds data_q.
- Reset asserted in any state aborts the command. No rsp_valid is issued, the enables drop on the reset edge, and a write already committed by the bank is not undone.

Decomposition:
- Shared package reg_seq_pkg: opcode constants OP_LDI/OP_MOV/OP_ALU/OP_OUT and state encodings.
- No sub-module: a single FSM plus datapath latches. The ALU remains external.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-MOV (in RD) -> next cycle cmd_ready=1, rb_read_en=0, rb_write_en=0, rsp_valid=0, no later rsp.
- LDI rx=4 imm=8'hAA -> rb_write_en high exactly 1 cycle with rx_sel=4 and wr_data=AA; rsp_valid 2 cycles after accept with rsp_data=AA; bank out_rx_data(4)=AA.
- MOV: LDI R3=8'h01, then MOV rx=0 ry=3 -> RD cycle shows read_en=1, ry_sel=3; WR writes 01 to R0; rsp_data=01 at latency 3.
- ALU (bench ALU = A+B): R1=8'hF0, R2=8'h20, ALU rx=1 ry=2 -> alu_a=F0, alu_b=20, R1<=8'h10 (wrap mod 2**DATA_W), rsp_data=10.
- OUT ry=3 after LDI R3=8'h5A -> rb_read_en 1 cycle, no write_en, rsp_data=5A at latency 2.
- Back-pressure: hold cmd_valid=1 with differing cmd_* during a busy MOV -> nothing accepted until cmd_ready returns. Check read_en & write_en never both 1 throughout the run.
